// File: rtl/ex_hazard_ctrl.sv
// Pipeline hazard controller for the EX stage: branch flush, multi-cycle
// EX occupancy and load-use stall, plus saturating stall/flush statistics.
module ex_hazard_ctrl #(
  parameter int MC_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_multi,
  input  logic        br_taken,
  input  logic        stat_clr,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_bubble,
  output logic        ex_hold,
  output logic        busy,
  output logic [15:0] stall_cycles,
  output logic [7:0]  flush_events
);

  typedef enum logic {
    RUN    = 1'b0,
    MCBUSY = 1'b1
  } state_t;

  // First MCBUSY cycle sees MC_LATENCY-1; release happens when it reaches 1.
  localparam logic [3:0] CNT_INIT = 4'(MC_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_q;
  logic [7:0]  flush_q;
  logic        load_use;

  // Register $zero never carries a real dependency.
  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

  // Output decode and next-state: branch > multi-cycle op > load-use.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    ex_hold      = 1'b0;
    if (!rst) begin
      // Reset keeps the pipeline frozen and emptied regardless of inputs.
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      state_d      = RUN;
      cnt_d        = 4'd0;
    end else if (br_taken) begin
      // Taken branch squashes everything younger, including a busy EX op.
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
      state_d      = RUN;
      cnt_d        = 4'd0;
    end else if (state_q == MCBUSY) begin
      if (cnt_q > 4'd1) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ex_hold      = 1'b1;
        exmem_bubble = 1'b1;
        cnt_d        = cnt_q - 4'd1;
      end else begin
        // Release cycle: EX result moves on, front end resumes.
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    end else if (ex_multi) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ex_hold      = 1'b1;
      exmem_bubble = 1'b1;
      state_d      = MCBUSY;
      cnt_d        = CNT_INIT;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign busy = rst && (state_q == MCBUSY);

  // FSM state and occupancy counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating statistics; clear wins over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= 16'd0;
      flush_q <= 8'd0;
    end else if (stat_clr) begin
      stall_q <= 16'd0;
      flush_q <= 8'd0;
    end else begin
      if (!pc_write && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (br_taken && (flush_q != 8'hFF))     flush_q <= flush_q + 8'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed testbench for ex_hazard_ctrl (MC_LATENCY = 4).
module tb_ex_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_mem_read, ex_multi, br_taken, stat_clr;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble, ex_hold, busy;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_events;
  logic [6:0]  ctl;

  int n_checks = 0;
  int n_errors = 0;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble, ex_hold, busy}
  localparam logic [6:0] C_RST  = 7'b0011100;
  localparam logic [6:0] C_IDLE = 7'b1100000;
  localparam logic [6:0] C_LU   = 7'b0001000;
  localparam logic [6:0] C_MC1  = 7'b0000110;
  localparam logic [6:0] C_HOLD = 7'b0000111;
  localparam logic [6:0] C_REL  = 7'b1100001;
  localparam logic [6:0] C_BR   = 7'b1111100;
  localparam logic [6:0] C_BRB  = 7'b1111101;

  ex_hazard_ctrl #(.MC_LATENCY(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .ex_multi     (ex_multi),
    .br_taken     (br_taken),
    .stat_clr     (stat_clr),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .exmem_bubble (exmem_bubble),
    .ex_hold      (ex_hold),
    .busy         (busy),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  assign ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble, ex_hold, busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic set_in(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                        input logic [4:0] rt_id, input logic multi, input logic br,
                        input logic clr);
    ex_mem_read = mr;
    ex_rt       = rt;
    id_rs       = rs;
    id_rt       = rt_id;
    ex_multi    = multi;
    br_taken    = br;
    stat_clr    = clr;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_stats();
    set_in(0, 0, 0, 0, 0, 0, 1);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  // One full MC_LATENCY=4 op with ex_multi held high; optional load-use alongside.
  task automatic op_seq(input string tag, input logic lu);
    logic [6:0] exp;
    for (int c = 0; c < 4; c++) begin
      set_in(lu, lu ? 5'd5 : 5'd0, lu ? 5'd5 : 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      settle();
      exp = (c == 0) ? C_MC1 : ((c == 3) ? C_REL : C_HOLD);
      check($sformatf("%s_c%0d", tag, c + 1), 32'(ctl), 32'(exp));
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    set_in(1, 5, 5, 0, 1, 1, 0);
    @(negedge clk);
    settle();
    check("rst_ctl", 32'(ctl), 32'(C_RST));
    tick();
    check("rst_stall", 32'(stall_cycles), 32'h0);
    check("rst_flush", 32'(flush_events), 32'h0);

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    settle();
    check("idle", 32'(ctl), 32'(C_IDLE));

    // Load-use through id_rs
    set_in(1, 5, 5, 0, 0, 0, 0);
    settle();
    check("lu_rs", 32'(ctl), 32'(C_LU));
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    settle();
    check("lu_rs_next", 32'(ctl), 32'(C_IDLE));
    check("lu_rs_stall", 32'(stall_cycles), 32'd1);

    // Load-use through id_rt
    set_in(1, 7, 3, 7, 0, 0, 0);
    settle();
    check("lu_rt", 32'(ctl), 32'(C_LU));
    tick();
    // $zero, mismatch and non-load cases never stall
    set_in(1, 0, 0, 0, 0, 0, 0);
    settle();
    check("lu_zero", 32'(ctl), 32'(C_IDLE));
    tick();
    set_in(1, 7, 3, 4, 0, 0, 0);
    settle();
    check("lu_miss", 32'(ctl), 32'(C_IDLE));
    tick();
    set_in(0, 5, 5, 5, 0, 0, 0);
    settle();
    check("lu_noload", 32'(ctl), 32'(C_IDLE));
    tick();
    check("lu_stall2", 32'(stall_cycles), 32'd2);
    clear_stats();
    settle();
    check("clr_stall", 32'(stall_cycles), 32'd0);

    // Single multi-cycle op
    op_seq("mc", 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    settle();
    check("mc_after", 32'(ctl), 32'(C_IDLE));
    check("mc_stall", 32'(stall_cycles), 32'd3);

    // Back-to-back ops
    clear_stats();
    op_seq("b2b_a", 1'b0);
    op_seq("b2b_b", 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    settle();
    check("b2b_after", 32'(ctl), 32'(C_IDLE));
    check("b2b_stall", 32'(stall_cycles), 32'd6);

    // Multi-cycle op with simultaneous load-use
    clear_stats();
    op_seq("mc_lu", 1'b1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    settle();
    check("mc_lu_stall", 32'(stall_cycles), 32'd3);

    // Branch abort in second MCBUSY cycle
    clear_stats();
    set_in(0, 0, 0, 0, 1, 0, 0);
    settle();
    check("ab_c1", 32'(ctl), 32'(C_MC1));
    tick();
    set_in(0, 0, 0, 0, 1, 1, 0);
    settle();
    check("ab_br", 32'(ctl), 32'(C_BRB));
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    settle();
    check("ab_after", 32'(ctl), 32'(C_IDLE));
    check("ab_stall", 32'(stall_cycles), 32'd1);
    check("ab_flush", 32'(flush_events), 32'd1);

    // Branch in RUN beats multi and load-use
    set_in(1, 5, 5, 0, 1, 1, 0);
    settle();
    check("br_run", 32'(ctl), 32'(C_BR));
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0);
    settle();
    check("br_run_after", 32'(ctl), 32'(C_IDLE));
    check("br_run_flush", 32'(flush_events), 32'd2);

    // Reset in the middle of MCBUSY
    clear_stats();
    set_in(0, 0, 0, 0, 1, 0, 0);
    settle();
    check("rmc_c1", 32'(ctl), 32'(C_MC1));
    tick();
    settle();
    check("rmc_c2", 32'(ctl), 32'(C_HOLD));
    #2 rst = 1'b0;
    #1;
    check("rmc_rst", 32'(ctl), 32'(C_RST));
    check("rmc_stall", 32'(stall_cycles), 32'd0);
    tick();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    settle();
    check("rmc_release", 32'(ctl), 32'(C_IDLE));
    op_seq("rmc_fresh", 1'b0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    settle();
    check("rmc_fresh_stall", 32'(stall_cycles), 32'd3);

    // Stall counter saturation and clear precedence
    clear_stats();
    set_in(1, 5, 5, 0, 0, 0, 0);
    repeat (70000) tick();
    settle();
    check("sat_stall", 32'(stall_cycles), 32'hFFFF);
    set_in(1, 5, 5, 0, 0, 0, 1);
    tick();
    set_in(1, 5, 5, 0, 0, 0, 0);
    settle();
    check("sat_clr", 32'(stall_cycles), 32'd0);

    // Flush counter saturation
    set_in(0, 0, 0, 0, 0, 1, 0);
    repeat (300) tick();
    settle();
    check("sat_flush", 32'(flush_events), 32'hFF);
    set_in(0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
